// File: rtl/gmii_rx_framer.sv
// GMII receive framer: preamble/SFD detection, FCS strip through a 5-byte delay line,
// CRC-32 and length checking, frame counters, and RGMII in-band link status decode.
module gmii_rx_framer #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        gmii_rx_clk,
   input  logic        rx_reset,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_last,
   output logic        rx_crc_ok,
   output logic        rx_len_err,
   output logic        rx_phy_err,
   output logic        link_up,
   output logic [1:0]  link_speed,
   output logic        link_duplex,
   output logic [15:0] frames_good,
   output logic [15:0] frames_bad
);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

   localparam logic [13:0] MIN_L   = 14'(MIN_LEN);
   localparam logic [13:0] MAX_L   = 14'(MAX_LEN);
   localparam logic [13:0] CNT_MAX = 14'h3FFF;
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [13:0] cnt_q, cnt_d;
   logic        perr_q, perr_d;
   logic [7:0]  dly_q [5];
   logic [7:0]  dly_d [5];
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        last_q, last_d;
   logic        crc_ok_q, crc_ok_d;
   logic        len_err_q, len_err_d;
   logic        phy_err_q, phy_err_d;
   logic        link_up_q, link_up_d;
   logic [1:0]  link_speed_q, link_speed_d;
   logic        link_duplex_q, link_duplex_d;
   logic [15:0] good_q, good_d;
   logic [15:0] bad_q, bad_d;
   logic [3:0]  ib_prev_q, ib_prev_d;
   logic        ib_vld_q, ib_vld_d;

   logic crc_match, len_bad, frame_good;

   assign crc_match  = (crc_q == RESIDUE);
   assign len_bad    = (cnt_q < MIN_L) || (cnt_q > MAX_L);
   assign frame_good = crc_match && !len_bad && !perr_q;

   always_comb begin
      state_d       = state_q;
      crc_d         = crc_q;
      cnt_d         = cnt_q;
      perr_d        = perr_q;
      dly_d         = dly_q;
      data_d        = 8'h00;
      valid_d       = 1'b0;
      last_d        = 1'b0;
      crc_ok_d      = 1'b0;
      len_err_d     = 1'b0;
      phy_err_d     = 1'b0;
      link_up_d     = link_up_q;
      link_speed_d  = link_speed_q;
      link_duplex_d = link_duplex_q;
      good_d        = good_q;
      bad_d         = bad_q;
      ib_prev_d     = ib_prev_q;
      ib_vld_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (gmii_rx_dv) begin
               state_d = (gmii_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
            end else if (!gmii_rx_er && (gmii_rxd[3:0] == gmii_rxd[7:4])) begin
               // Status nibble must repeat on two back-to-back qualifying cycles.
               ib_vld_d  = 1'b1;
               ib_prev_d = gmii_rxd[3:0];
               if (ib_vld_q && (ib_prev_q == gmii_rxd[3:0])) begin
                  link_up_d     = gmii_rxd[0];
                  link_speed_d  = gmii_rxd[2:1];
                  link_duplex_d = gmii_rxd[3];
               end
            end
         end
         S_PREAMBLE: begin
            if (!gmii_rx_dv) begin
               state_d = S_IDLE;
            end else if (gmii_rx_er) begin
               state_d = S_DROP;
            end else if (gmii_rxd == 8'h55) begin
               state_d = S_PREAMBLE;
            end else if (gmii_rxd == 8'hD5) begin
               state_d = S_DATA;
               crc_d   = 32'hFFFFFFFF;
               cnt_d   = 14'd0;
               perr_d  = 1'b0;
            end else begin
               state_d = S_DROP;
            end
         end
         S_DATA: begin
            if (gmii_rx_dv) begin
               crc_d = crc_byte(crc_q, gmii_rxd);
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 14'd1;
               dly_d[0] = gmii_rxd;
               for (int i = 1; i < 5; i++) dly_d[i] = dly_q[i-1];
               if (gmii_rx_er) perr_d = 1'b1;
               if (cnt_q >= 14'd5) begin
                  valid_d = 1'b1;
                  data_d  = dly_q[4];
               end
            end else begin
               state_d = S_IDLE;
               // The four youngest delay-line bytes are the FCS and are never emitted.
               if (cnt_q >= 14'd5) begin
                  valid_d   = 1'b1;
                  last_d    = 1'b1;
                  data_d    = dly_q[4];
                  crc_ok_d  = crc_match;
                  len_err_d = len_bad;
                  phy_err_d = perr_q;
                  if (frame_good) begin
                     if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
                  end else begin
                     if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
                  end
               end else begin
                  if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
               end
            end
         end
         S_DROP: begin
            if (!gmii_rx_dv) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge gmii_rx_clk) begin
      if (rx_reset) begin
         state_q       <= S_IDLE;
         crc_q         <= 32'd0;
         cnt_q         <= 14'd0;
         perr_q        <= 1'b0;
         for (int i = 0; i < 5; i++) dly_q[i] <= 8'h00;
         data_q        <= 8'h00;
         valid_q       <= 1'b0;
         last_q        <= 1'b0;
         crc_ok_q      <= 1'b0;
         len_err_q     <= 1'b0;
         phy_err_q     <= 1'b0;
         link_up_q     <= 1'b0;
         link_speed_q  <= 2'b00;
         link_duplex_q <= 1'b0;
         good_q        <= 16'd0;
         bad_q         <= 16'd0;
         ib_prev_q     <= 4'h0;
         ib_vld_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         crc_q         <= crc_d;
         cnt_q         <= cnt_d;
         perr_q        <= perr_d;
         dly_q         <= dly_d;
         data_q        <= data_d;
         valid_q       <= valid_d;
         last_q        <= last_d;
         crc_ok_q      <= crc_ok_d;
         len_err_q     <= len_err_d;
         phy_err_q     <= phy_err_d;
         link_up_q     <= link_up_d;
         link_speed_q  <= link_speed_d;
         link_duplex_q <= link_duplex_d;
         good_q        <= good_d;
         bad_q         <= bad_d;
         ib_prev_q     <= ib_prev_d;
         ib_vld_q      <= ib_vld_d;
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign rx_last     = last_q;
   assign rx_crc_ok   = crc_ok_q;
   assign rx_len_err  = len_err_q;
   assign rx_phy_err  = phy_err_q;
   assign link_up     = link_up_q;
   assign link_speed  = link_speed_q;
   assign link_duplex = link_duplex_q;
   assign frames_good = good_q;
   assign frames_bad  = bad_q;

endmodule
